rf_cache_bank: RTL
==================

Name: rf_cache_bank

Overview:
- Parametrised successor to the team's single-port 32x256 cache register file.
- Generalised in depth and width; adds per-byte write enables and an optional registered read-output stage.
- Adds a sequential clear engine: after reset or on request, it zeroes the array one entry per cycle instead of resetting all storage at once.
- Used as a data/tag bank under the cache controller, which must honour the busy output.

Parameters:
- DEPTH, 32, number of entries; power of two, >=2.
- WIDTH, 256, entry width in bits; multiple of 8.
- OUT_REG, 0, 1 adds a second output register stage (read latency 2 instead of 1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- A  in  log2(DEPTH)  entry address.
- D  in  WIDTH  write data.
- WEN  in  1  write enable, active-low (0 = write).
- BEN  in  WIDTH/8  byte enables, active-high; bit k covers D[8k+7:8k].
- clr  in  1  clear request, single-cycle pulse, sampled only in IDLE.
- Q  out  WIDTH  read/write-through data.
- busy  out  1  clear sweep in progress; accesses are dropped while high.

Behaviour:
- Reset (rst=1 at posedge):
  - state<=CLEAR, ptr<=0, Q<=0, pipeline register<=0, busy<=1.
  - Array contents are not reset directly; they are zeroed by the sweep.
  - While rst is held, ptr stays at 0.
- FSM has two states, IDLE and CLEAR.
- CLEAR:
  - Each cycle mem[ptr]<=0 and ptr<=ptr+1.
  - When ptr==DEPTH-1, state<=IDLE on that edge.
  - busy is registered and high exactly DEPTH cycles after the first non-reset edge.
  - ptr is log2(DEPTH) bits. It does not wrap into a second pass.
- CLEAR, accesses and requests:
  - A/D/WEN/BEN are ignored: no array write, Q<=0.
  - clr is ignored in CLEAR (no restart).
- IDLE, clr=1:
  - state<=CLEAR, ptr<=0.
  - Any access presented in that same cycle is still performed.
  - busy rises on the next edge.
- IDLE, write (WEN=0):
  - For each byte k with BEN[k]=1, mem[A] byte k <= D byte k; bytes with BEN[k]=0 are retained.
  - Q stage 1 <= merged word (old bytes where BEN=0, new bytes where BEN=1), i.e. write-through.
  - BEN all-zero is a legal no-op write: the array is unchanged and Q stage 1 <= mem[A].
- IDLE, read (WEN=1):
  - Q stage 1 <= mem[A].
  - BEN is don't-care.
- Latency and hold:
  - Q is valid 1 cycle after the access edge when OUT_REG=0, 2 cycles when OUT_REG=1.
  - Q holds its value only until the next edge: every IDLE edge updates it (there is no read-enable).
- Back-to-back read-after-write to the same address on consecutive cycles returns the written data. No bypass path is needed because the write lands in the array at the first edge.
- Reset mid-sweep: the sweep restarts from ptr=0 and busy remains high, so a full DEPTH-cycle sweep always follows any reset.
- The OUT_REG stage is also zeroed on reset and during CLEAR.

Decomposition:
- Shared package rf_pkg holds:
  - state enum {IDLE, CLEAR};
  - function clog2;
  - localparam helpers ADDR_W = clog2(DEPTH) and BYTES = WIDTH/8.
- A natural sub-module is rf_byte_merge: a combinational merge of old word, new word and BEN, reused by the cache controller's fill path.
- The array, FSM and output stages stay in rf_cache_bank.

Test Plan:
- Reset then sweep: rst=1 for 3 cycles, then 0.
  - busy=1 for exactly 32 cycles, then 0.
  - Q=0 throughout.
  - Reads of A=0..31 afterwards all return 0.
- Full write then read: write A=5, D=256'hA5 repeated, BEN=all 1s.
  - Q=256'hA5.. next cycle.
  - A read of A=5 on the following cycle returns the same value.
- Byte merge:
  - Pre-write A=7 with 256'hFF.. (all bytes 0xFF).
  - Write A=7, D=0, BEN=32'h0000_000F.
  - Q and a later read return 256'hFF..FF_0000_0000 (low 4 bytes zero).
- Clear request with a same-cycle write:
  - In IDLE, assert clr=1 with a write of A=3, D=1.
  - Q=1 next cycle, then busy=1 for 32 cycles.
  - Writes attempted during the sweep are dropped and Q=0.
  - A=3 reads 0 afterwards.
- Reset mid-sweep: pulse rst at sweep cycle 10.
  - busy stays 1 for 32 further cycles, not 22.
- OUT_REG=1 build: repeat the full-write scenario.
  - Q appears 2 cycles after the access edge.
  - A back-to-back read stream on A=0,1,2 yields data in the same order, 2-cycle lag.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared state type and sizing helpers for the parametrised cache register-file bank.
package rf_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

    localparam int DEF_DEPTH = 32;
    localparam int DEF_WIDTH = 256;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_byte_merge.sv
// Combinational byte-lane merge: lanes with i_ben set take i_new, the rest keep i_old.
module rf_byte_merge #(
    parameter int WIDTH = 256,
    localparam int BYTES = WIDTH / 8
) (
    input  logic [WIDTH-1:0] i_old,
    input  logic [WIDTH-1:0] i_new,
    input  logic [BYTES-1:0] i_ben,
    output logic [WIDTH-1:0] o_merged
);

    always_comb begin
        o_merged = i_old;
        for (int k = 0; k < BYTES; k++) begin
            if (i_ben[k]) begin
                o_merged[8*k +: 8] = i_new[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/rf_cache_bank.sv
// Single-port byte-writable register-file bank with a one-entry-per-cycle clear sweep.
// Q follows an access by 1 edge (2 with OUT_REG); accesses are dropped while busy is high.
module rf_cache_bank
    import rf_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int OUT_REG = 0,
    localparam int ADDR_W = clog2(DEPTH),
    localparam int BYTES  = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] A,
    input  logic [WIDTH-1:0]  D,
    input  logic              WEN,
    input  logic [BYTES-1:0]  BEN,
    input  logic              clr,
    output logic [WIDTH-1:0]  Q,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    rf_state_e         r_state;
    rf_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [WIDTH-1:0]  w_old;
    logic [WIDTH-1:0]  w_merged;
    logic [WIDTH-1:0]  w_rd;
    logic [WIDTH-1:0]  r_q1;
    logic              r_busy;

    assign w_old = r_mem[A];

    rf_byte_merge #(.WIDTH(WIDTH)) u_merge (
        .i_old    (w_old),
        .i_new    (D),
        .i_ben    (BEN),
        .o_merged (w_merged)
    );

    // Write-through: a write returns the merged word, a read the stored one.
    assign w_rd = WEN ? w_old : w_merged;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (clr) w_state_nxt = CLEAR;
            CLEAR:   if (r_ptr == LAST) w_state_nxt = IDLE;
            default: w_state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= '0;
            r_q1   <= '0;
            r_busy <= 1'b1;
        end else begin
            r_busy <= (w_state_nxt == CLEAR);
            if (r_state == CLEAR) begin
                r_ptr <= r_ptr + 1'b1;
                r_q1  <= '0;
            end else begin
                r_q1 <= w_rd;
                if (clr) begin
                    r_ptr <= '0;
                end
            end
        end
    end

    // Storage carries no reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == CLEAR) begin
                r_mem[r_ptr] <= '0;
            end else if (!WEN) begin
                r_mem[A] <= w_merged;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [WIDTH-1:0] r_q2;
        always_ff @(posedge clk) begin
            if (rst || (r_state == CLEAR)) begin
                r_q2 <= '0;
            end else begin
                r_q2 <= r_q1;
            end
        end
        assign Q = r_q2;
    end else begin : g_no_out_reg
        assign Q = r_q1;
    end

    assign busy = r_busy;

endmodule
